// File: rtl/johnson_counter_ctl_if.sv
// Control/status bundle for johnson_counter_ctl: step/load requests in, ring state and decode out.
// PW follows WIDTH and is not meant to be overridden.
interface johnson_counter_ctl_if #(
   parameter int WIDTH = 4
);
   localparam int PW = $clog2(2 * WIDTH);

   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic [PW-1:0]    phase;
   logic             wrap;
   logic             illegal;

   modport master (
      output en, dir, load, load_val,
      input  out, phase, wrap, illegal
   );

   modport slave (
      input  en, dir, load, load_val,
      output out, phase, wrap, illegal
   );
endinterface

// File: rtl/johnson_counter_ctl.sv
// Bidirectional Johnson counter with load, phase decode and wrap pulse.
// Define JOHNSON_SELF_CORRECT_EN to replace illegal load values with zero and flag them.
module johnson_counter_ctl #(
   parameter int WIDTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   johnson_counter_ctl_if.slave bus
);
   localparam int PW = $clog2(2 * WIDTH);
   localparam int N  = 2 * WIDTH;

   logic [WIDTH-1:0] out_p1;
   logic [WIDTH-1:0] out_nxt;
   logic [PW-1:0]    phase_p1;
   logic [PW-1:0]    phase_nxt;
   logic             wrap_p1;
   logic             wrap_nxt;
`ifdef JOHNSON_SELF_CORRECT_EN
   logic             illegal_p1;
   logic             illegal_nxt;
`endif

   function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] v);
      return {~v[0], v[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ~v[WIDTH-1]};
   endfunction

   // A legal Johnson state has at most one 0/1 boundary between adjacent bits.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      int edges;
      edges = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) edges++;
      end
      return (edges <= 1);
   endfunction

   function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v);
      int k;
      k = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) k++;
      end
      if (!is_legal(v) || k == 0) return '0;
      if (v[WIDTH-1])             return PW'(k);
      return PW'(N - k);
   endfunction

   // Stage p0: next-state selection (load > en > hold)
   always_comb begin
      out_nxt  = out_p1;
      wrap_nxt = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
      illegal_nxt = 1'b0;
`endif
      if (bus.load) begin
`ifdef JOHNSON_SELF_CORRECT_EN
         if (is_legal(bus.load_val)) begin
            out_nxt = bus.load_val;
         end else begin
            out_nxt     = '0;
            illegal_nxt = 1'b1;
         end
`else
         out_nxt = bus.load_val;
`endif
      end else if (bus.en) begin
         if (bus.dir) begin
            out_nxt  = step_rev(out_p1);
            wrap_nxt = (out_p1 == '0);
         end else begin
            out_nxt  = step_fwd(out_p1);
            wrap_nxt = (out_p1 == {{(WIDTH-1){1'b0}}, 1'b1});
         end
      end
      phase_nxt = phase_of(out_nxt);
   end

   // Stage p1: registered state and decode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_p1   <= '0;
         phase_p1 <= '0;
         wrap_p1  <= 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
         illegal_p1 <= 1'b0;
`endif
      end else begin
         out_p1   <= out_nxt;
         phase_p1 <= phase_nxt;
         wrap_p1  <= wrap_nxt;
`ifdef JOHNSON_SELF_CORRECT_EN
         illegal_p1 <= illegal_nxt;
`endif
      end
   end

   assign bus.out   = out_p1;
   assign bus.phase = phase_p1;
   assign bus.wrap  = wrap_p1;
`ifdef JOHNSON_SELF_CORRECT_EN
   assign bus.illegal = illegal_p1;
`else
   assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_johnson_counter_ctl.sv
// Bench for johnson_counter_ctl (WIDTH=4): directed plan scenarios plus random traffic
// checked against a phase-index model of the Johnson sequence.
module tb_johnson_counter_ctl;
   localparam int WIDTH = 4;
   localparam int PW    = $clog2(2 * WIDTH);
   localparam int N     = 2 * WIDTH;

   logic clk = 1'b0;
   logic rst_n;

   johnson_counter_ctl_if #(.WIDTH(WIDTH)) bus ();
   johnson_counter_ctl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] tbl [N];
   int               m_p;
   bit               m_legal;
   logic [WIDTH-1:0] m_raw;
   bit               m_wrap;
   bit               m_ill;

   // Pattern at sequence position p: p ones from the MSB for p<=WIDTH, else 2W-p ones from the LSB.
   function automatic logic [WIDTH-1:0] pat(input int p);
      logic [WIDTH-1:0] v;
      v = '0;
      if (p <= WIDTH) begin
         for (int i = 0; i < p; i++) v[WIDTH-1-i] = 1'b1;
      end else begin
         for (int i = 0; i < N - p; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic int find(input logic [WIDTH-1:0] v);
      for (int i = 0; i < N; i++) if (tbl[i] == v) return i;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit d, input bit l,
                             input logic [WIDTH-1:0] lv);
      int idx;
      m_wrap = 1'b0;
      m_ill  = 1'b0;
      if (!r) begin
         m_legal = 1'b1;
         m_p     = 0;
      end else if (l) begin
         idx = find(lv);
         if (idx >= 0) begin
            m_legal = 1'b1;
            m_p     = idx;
         end else begin
`ifdef JOHNSON_SELF_CORRECT_EN
            m_legal = 1'b1;
            m_p     = 0;
            m_ill   = 1'b1;
`else
            m_legal = 1'b0;
            m_raw   = lv;
`endif
         end
      end else if (e) begin
         if (m_legal) begin
            if (!d) begin
               m_wrap = (m_p == N - 1);
               m_p    = (m_p + 1) % N;
            end else begin
               m_wrap = (m_p == 0);
               m_p    = (m_p + N - 1) % N;
            end
         end else begin
            m_raw = d ? {m_raw[WIDTH-2:0], ~m_raw[WIDTH-1]} : {~m_raw[0], m_raw[WIDTH-1:1]};
            idx   = find(m_raw);
            if (idx >= 0) begin
               m_legal = 1'b1;
               m_p     = idx;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model on the edge, then compare all outputs.
   task automatic apply(input bit r, input bit e, input bit d, input bit l,
                        input logic [WIDTH-1:0] lv);
      logic [WIDTH-1:0] exp_out;
      int               exp_ph;
      rst_n        = r;
      bus.en       = e;
      bus.dir      = d;
      bus.load     = l;
      bus.load_val = lv;
      @(posedge clk);
      model_edge(r, e, d, l, lv);
      #1;
      exp_out = m_legal ? pat(m_p) : m_raw;
      exp_ph  = m_legal ? m_p : 0;
      check("out",     32'(bus.out),     32'(exp_out));
      check("phase",   32'(bus.phase),   32'(exp_ph));
      check("wrap",    32'(bus.wrap),    32'(m_wrap));
      check("illegal", 32'(bus.illegal), 32'(m_ill));
   endtask

   logic [WIDTH-1:0] fwd_out [9];
   int               fwd_ph  [9];

   initial begin
      for (int i = 0; i < N; i++) tbl[i] = pat(i);
      fwd_out = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
      fwd_ph  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
      m_p = 0; m_legal = 1'b1; m_raw = '0; m_wrap = 1'b0; m_ill = 1'b0;

      // reset values
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      apply(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111);
      check("rst_out", 32'(bus.out), 32'h0);
      check("rst_phase", 32'(bus.phase), 32'h0);
      check("rst_wrap", 32'(bus.wrap), 32'h0);

      // full forward lap
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
         check("fwd_out", 32'(bus.out), 32'(fwd_out[i]));
         check("fwd_phase", 32'(bus.phase), 32'(fwd_ph[i]));
         check("fwd_wrap", 32'(bus.wrap), (i == 7) ? 32'd1 : 32'd0);
      end

      // reverse from zero
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("rev_out0", 32'(bus.out), 32'h1);
      check("rev_ph0", 32'(bus.phase), 32'd7);
      check("rev_wrap0", 32'(bus.wrap), 32'd1);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("rev_out1", 32'(bus.out), 32'h3);
      check("rev_ph1", 32'(bus.phase), 32'd6);
      check("rev_wrap1", 32'(bus.wrap), 32'd0);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("rev_out2", 32'(bus.out), 32'h7);
      check("rev_ph2", 32'(bus.phase), 32'd5);

      // hold at 1110, then direction changes with no bubble
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, i[0], 1'b0, 4'b0000);
         check("hold_out", 32'(bus.out), 32'hE);
         check("hold_wrap", 32'(bus.wrap), 32'd0);
      end
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("dir_rev_out", 32'(bus.out), 32'hC);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      check("dir_fwd_out", 32'(bus.out), 32'hF);
      check("dir_fwd_wrap", 32'(bus.wrap), 32'd0);

      // load beats en; reset beats load
      apply(1'b1, 1'b1, 1'b0, 1'b1, 4'b0011);
      check("load_out", 32'(bus.out), 32'h3);
      check("load_phase", 32'(bus.phase), 32'd6);
      check("load_wrap", 32'(bus.wrap), 32'd0);
      apply(1'b0, 1'b1, 1'b0, 1'b1, 4'b0111);
      check("rstload_out", 32'(bus.out), 32'h0);
      check("rstload_phase", 32'(bus.phase), 32'd0);

      // illegal load value
      apply(1'b1, 1'b0, 1'b0, 1'b1, 4'b0101);
`ifdef JOHNSON_SELF_CORRECT_EN
      check("ill_out", 32'(bus.out), 32'h0);
      check("ill_phase", 32'(bus.phase), 32'd0);
      check("ill_flag", 32'(bus.illegal), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
      check("ill_flag_clr", 32'(bus.illegal), 32'd0);
`else
      check("ill_out", 32'(bus.out), 32'h5);
      check("ill_phase", 32'(bus.phase), 32'd0);
      check("ill_flag", 32'(bus.illegal), 32'd0);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      check("ill_step", 32'(bus.out), 32'h2);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 99) >= 3), ($urandom_range(0, 3) != 0), 1'($urandom),
               ($urandom_range(0, 9) == 0), WIDTH'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/johnson_counter_ctl.md
# johnson_counter_ctl

Parametrised bidirectional Johnson (twisted-ring) counter with enable, parallel load, phase-index decode and wrap pulse. Generates 2·WIDTH-state sequences for phase generators, sequencers and clock-enable distribution in the lab designs. Successor to the fixed-direction free-running Johnson register; adds direction control, stall, load and state decode, plus optional illegal-state detection and recovery.

## Interface
- WIDTH, 4, ring length in bits; legal range 2..32; sequence length 2·WIDTH.
- PW, $clog2(2*WIDTH), width of phase output; derived, not overridden.

- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- en  input  1  advance one step per cycle when high.
- dir  input  1  0 = forward (shift right, MSB fill), 1 = reverse (shift left, LSB fill).
- load  input  1  parallel load request; priority over en.
- load_val  input  WIDTH  value written on load.
- out  output  WIDTH  counter state (registered).
- phase  output  PW  index 0..2·WIDTH−1 of current state (registered).
- wrap  output  1  one-cycle pulse, sequence wrapped (registered).
- illegal  output  1  one-cycle pulse, illegal load value corrected (registered; see Configuration).

## Operation
- Per-edge priority: !rst_n > load > en > hold.
- Forward step: out ← {~out[0], out[WIDTH-1:1]}. WIDTH=4: 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Reverse step: out ← {out[WIDTH-2:0], ~out[WIDTH-1]}; exact inverse of forward.
- Phase index for legal state with k ones: 0 if k=0; k if out[WIDTH-1]=1; 2·WIDTH−k otherwise. phase updated in same edge as out, always consistent with out.
- Legal states: all-zero, MSB-aligned contiguous ones (1..10..0), LSB-aligned contiguous ones (0..01..1); exactly 2·WIDTH patterns.
- wrap = 1 for the cycle after an en step taking phase 2·WIDTH−1→0 (forward) or 0→2·WIDTH−1 (reverse); 0 otherwise, including after load and hold.
- dir may change any cycle; the next en step uses the new dir with no bubble.
- load with legal load_val: out ← load_val, phase ← its index, wrap ← 0, illegal ← 0.
- load with illegal load_val: depends on JOHNSON_SELF_CORRECT_EN.

## Timing
- Reset (rst_n low at rising edge): out = 0, phase = 0, wrap = 0, illegal = 0. Asynchronous deassertion not supported; rst_n sampled only on clk.
- Reset mid-sequence or coincident with load/en: reset wins; state 0 on next cycle.
- Latency: one cycle from en/load sample to out/phase/wrap/illegal update; no combinational input→output paths.
- en low: all outputs hold except wrap and illegal, which return to 0.
- load and en both high: load wins, no step that cycle.

## Configuration
- JOHNSON_SELF_CORRECT_EN defined: illegal load_val loads 0, phase 0, illegal = 1 for one cycle. out is then always a legal state.
- Undefined: load_val loaded verbatim and shifted by the normal rules. phase for an illegal state reads 0. illegal tied 0. The detection logic is not synthesised.

## Test plan
All scenarios use WIDTH=4.
- Reset, then en=1, dir=0 for 9 cycles -> out 1000,1100,1110,1111,0111,0011,0001,0000,1000; phase 1..7,0,1; wrap high only in the cycle out=0000.
- From out=0000, en=1, dir=1 for 3 cycles -> out 0001 (phase 7, wrap=1), 0011 (phase 6), 0111 (phase 5).
- At out=1110, en=0 for 3 cycles, then dir toggles with en=1 -> out holds 1110; then 1100 (reverse) or 1111 (forward); wrap stays 0.
- load=1, load_val=0011, en=1 -> next out=0011, phase=6, wrap=0. rst_n=0 with load=1 -> out=0000, phase=0.
- load_val=0101 with macro -> out=0000, phase=0, illegal=1 for one cycle. Without macro -> out=0101, phase=0, illegal=0, and the next forward step gives 0010.
